tape_access_ctrl: RTL
=====================

TAPE_ACCESS_CTRL -- requirements
Module: tape_access_ctrl

Interface
REQ-001 SHALL have parameter CELL_W, default 8, data cell width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, tape cells (power of 2); ADDR_W = clog2(DEPTH).
REQ-003 SHALL have port clk_i  input  1  system clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  core presents a tape command.
REQ-006 SHALL have port cmd_ready_o  output  1  controller can accept a command.
REQ-007 SHALL have port cmd_op_i  input  3  opcode (see REQ-014).
REQ-008 SHALL have port cmd_data_i  input  CELL_W  store data for CELL_LOAD.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_data_o  output  CELL_W  result value; held until next response.
REQ-011 SHALL have port rsp_zero_o  output  1  rsp_data_o == 0 (branch decision).
REQ-012 SHALL have port ptr_o  output  ADDR_W  current data pointer.
REQ-013 SHALL have tape ports mem_ren_o (out, 1), mem_raddr_o (out, ADDR_W), mem_rdata_i (in, CELL_W), mem_wen_o (out, 1), mem_waddr_o (out, ADDR_W), mem_wdata_o (out, CELL_W); these drive a 1-cycle-latency, write-first tape RAM.

Function
REQ-014 SHALL decode opcodes: 0 PTR_INC, 1 PTR_DEC, 2 CELL_INC, 3 CELL_DEC, 4 CELL_LOAD, 5 CELL_READ, 6-7 NOP.
REQ-015 SHALL implement FSM states IDLE, RD, RSP; cmd_ready_o = 1 only in IDLE.
REQ-016 SHALL accept a command in cycle T when cmd_valid_i && cmd_ready_o; cmd_op_i/cmd_data_i are sampled only then.
REQ-017 PTR_INC/PTR_DEC SHALL update ptr modulo DEPTH at end of T (DEPTH-1 +1 -> 0; 0 -1 -> DEPTH-1), go IDLE->RSP.
REQ-018 CELL_LOAD SHALL assert mem_wen_o combinationally in T with waddr=ptr, wdata=cmd_data_i, go IDLE->RSP; rsp_data_o = cmd_data_i.
REQ-019 CELL_INC/CELL_DEC/CELL_READ SHALL assert mem_ren_o combinationally in T with raddr=ptr, go IDLE->RD.
REQ-020 In RD, CELL_INC/CELL_DEC SHALL assert mem_wen_o with waddr=ptr, wdata = mem_rdata_i +/-1 modulo 2^CELL_W (0xFF+1 -> 0x00, 0x00-1 -> 0xFF); CELL_READ SHALL not write; RD->RSP always.
REQ-021 rsp_data_o SHALL be: new cell value for cell ops, mem_rdata_i for CELL_READ, zero-extended new ptr for pointer ops, 0 for NOP.
REQ-022 RSP SHALL assert rsp_valid_o for exactly one cycle, then return to IDLE; no response backpressure.
REQ-023 Latency: pointer/LOAD/NOP response at T+1; INC/DEC/READ response at T+2; next acceptance no earlier than T+2 / T+3 respectively.
REQ-024 mem_ren_o and mem_wen_o SHALL never assert outside cases REQ-018..REQ-020; both low in RSP and in idle without accepted command.
REQ-025 mem_raddr_o/mem_waddr_o SHALL equal ptr_o at all times.
REQ-026 NOP (6,7) SHALL touch neither ptr nor tape and respond at T+1.

Reset
REQ-027 rst_i low SHALL asynchronously force state IDLE, ptr 0, rsp_data_o 0, rsp_valid_o 0; hence rsp_zero_o 1, cmd_ready_o 1, mem_ren_o/mem_wen_o 0.
REQ-028 Reset during RD SHALL abort the operation with no write issued and no response generated.
REQ-029 First command SHALL be acceptable in the first clock edge after rst_i deasserts.

Structure
REQ-030 Opcode constants and state encodings SHALL live in the shared package tinybf_pkg.
REQ-031 Block SHALL be a single module with no sub-modules; the tape RAM is instantiated alongside it by the integrator.

Verification
REQ-032 Reset, CELL_INC x3 at ptr 0 -> responses 1,2,3 each at T+2, tape[0]=0x03, rsp_zero_o=0.
REQ-033 ptr 0, PTR_DEC -> ptr_o=7, rsp_data_o=7 at T+1; PTR_INC -> ptr_o=0, rsp_zero_o=1.
REQ-034 CELL_LOAD 0xFF, CELL_INC -> response 0x00, rsp_zero_o=1; CELL_DEC -> 0xFF.
REQ-035 CELL_LOAD 0x5A at ptr 2, PTR_INC, PTR_DEC, CELL_READ -> rsp_data_o=0x5A at T+2, no mem_wen_o in read.
REQ-036 cmd_valid_i held high continuously with mixed ops -> cmd_ready_o low in RD/RSP, no command lost or duplicated, exactly one rsp_valid_o per accept.
REQ-037 Assert rst_i in RD of CELL_INC -> no mem_wen_o, no rsp_valid_o, ptr_o=0, cmd_ready_o=1 immediately.

Source files
------------

// File: rtl/tinybf_pkg.sv
// ---------------------------------------------------------------------------
// tinybf_pkg
// Shared definitions for the tape access controller: command opcodes and
// controller state encodings, plus small decode helpers used by the
// controller's command path.
// ---------------------------------------------------------------------------
package tinybf_pkg;

  // Tape command opcodes as presented on cmd_op_i.
  typedef enum logic [2:0] {
    OP_PTR_INC   = 3'd0,
    OP_PTR_DEC   = 3'd1,
    OP_CELL_INC  = 3'd2,
    OP_CELL_DEC  = 3'd3,
    OP_CELL_LOAD = 3'd4,
    OP_CELL_READ = 3'd5,
    OP_NOP6      = 3'd6,
    OP_NOP7      = 3'd7
  } tape_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RSP  = 2'd2
  } tape_state_e;

  // Commands that need the current cell value from the tape before they can
  // complete, and therefore spend a cycle in ST_RD.
  function automatic logic op_needs_read(input tape_op_e op);
    return (op == OP_CELL_INC) || (op == OP_CELL_DEC) || (op == OP_CELL_READ);
  endfunction

  // Commands that only move the data pointer.
  function automatic logic op_is_ptr(input tape_op_e op);
    return (op == OP_PTR_INC) || (op == OP_PTR_DEC);
  endfunction

endpackage : tinybf_pkg

// File: rtl/tape_access_ctrl.sv
// ---------------------------------------------------------------------------
// tape_access_ctrl
// Executes single tape commands from the core against an external
// 1-cycle-latency, write-first tape RAM. Owns the data pointer.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (ready only in IDLE)
//   cmd_op_i, cmd_data_i  opcode and CELL_LOAD store data
//   rsp_valid_o           one-cycle completion pulse
//   rsp_data_o            result value, held until the next response
//   rsp_zero_o            rsp_data_o == 0
//   ptr_o                 current data pointer
//   mem_*                 tape RAM read/write port controls
//
// Timing
//   PTR_INC/PTR_DEC/CELL_LOAD/NOP : IDLE -> RSP            (response at T+1)
//   CELL_INC/CELL_DEC/CELL_READ   : IDLE -> RD -> RSP      (response at T+2)
// ---------------------------------------------------------------------------
module tape_access_ctrl
  import tinybf_pkg::*;
#(
  parameter int CELL_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [CELL_W-1:0] cmd_data_i,

  output logic              rsp_valid_o,
  output logic [CELL_W-1:0] rsp_data_o,
  output logic              rsp_zero_o,

  output logic [ADDR_W-1:0] ptr_o,

  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [CELL_W-1:0] mem_rdata_i,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [CELL_W-1:0] mem_wdata_o
);

  // Cell arithmetic wraps modulo 2^CELL_W (no saturation).
  function automatic logic [CELL_W-1:0] cell_step(input logic [CELL_W-1:0] v,
                                                  input logic               dec);
    return dec ? (v - CELL_W'(1)) : (v + CELL_W'(1));
  endfunction

  // Pointer arithmetic wraps modulo DEPTH (DEPTH is a power of two).
  function automatic logic [ADDR_W-1:0] ptr_step(input logic [ADDR_W-1:0] p,
                                                 input logic               dec);
    return dec ? (p - ADDR_W'(1)) : (p + ADDR_W'(1));
  endfunction

  tape_state_e       r_state;
  tape_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [CELL_W-1:0] r_rsp_data;
  logic [CELL_W-1:0] w_rsp_nxt;
  tape_op_e          r_op;
  tape_op_e          w_op;
  logic              w_accept;
  logic              w_ren;
  logic              w_wen;
  logic [CELL_W-1:0] w_wdata;

  assign w_op     = tape_op_e'(cmd_op_i);
  assign w_accept = cmd_valid_i && (r_state == ST_IDLE);

  // Next-state, datapath and tape strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rsp_nxt   = r_rsp_data;
    w_ren       = 1'b0;
    w_wen       = 1'b0;
    w_wdata     = cmd_data_i;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (op_is_ptr(w_op)) begin
            w_ptr_nxt   = ptr_step(r_ptr, w_op == OP_PTR_DEC);
            w_rsp_nxt   = CELL_W'(w_ptr_nxt);
            w_state_nxt = ST_RSP;
          end else if (w_op == OP_CELL_LOAD) begin
            w_wen       = 1'b1;
            w_wdata     = cmd_data_i;
            w_rsp_nxt   = cmd_data_i;
            w_state_nxt = ST_RSP;
          end else if (op_needs_read(w_op)) begin
            // Cell value arrives from the RAM during ST_RD.
            w_ren       = 1'b1;
            w_state_nxt = ST_RD;
          end else begin
            w_rsp_nxt   = '0;
            w_state_nxt = ST_RSP;
          end
        end
      end

      ST_RD: begin
        case (r_op)
          OP_CELL_INC, OP_CELL_DEC: begin
            w_wen     = 1'b1;
            w_wdata   = cell_step(mem_rdata_i, r_op == OP_CELL_DEC);
            w_rsp_nxt = w_wdata;
          end
          default: begin
            w_rsp_nxt = mem_rdata_i;
          end
        endcase
        w_state_nxt = ST_RSP;
      end

      ST_RSP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control and architectural state: asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rsp_data <= w_rsp_nxt;
    end
  end

  // Latched opcode is only consulted in ST_RD, which is always entered via
  // an accept that loads it, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op <= w_op;
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RSP);
  assign rsp_data_o  = r_rsp_data;
  assign rsp_zero_o  = (r_rsp_data == '0);
  assign ptr_o       = r_ptr;

  assign mem_ren_o   = w_ren;
  assign mem_raddr_o = r_ptr;
  assign mem_wen_o   = w_wen;
  assign mem_waddr_o = r_ptr;
  assign mem_wdata_o = w_wdata;

endmodule : tape_access_ctrl
